// File: rtl/f5_equiv_sequencer.sv
// Self-check sequencer: sweeps every N-bit vector onto two function instances and
// compares their outputs. Optional macro F5_STOP_ON_MISMATCH_EN ends the sweep at the first mismatch.
module f5_equiv_sequencer #(
    parameter int N      = 3,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sa,
    input  logic         sb,
    output logic [N-1:0] vec,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         err_valid,
    output logic [N-1:0] first_err
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N-1:0]  VEC_LAST = '1;
    localparam logic [N:0]    ERR_MAX  = {1'b1, {N{1'b0}}};

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  vec_q, vec_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [N:0]    err_count_q, err_count_d;
    logic          err_valid_q, err_valid_d;
    logic [N-1:0]  first_err_q, first_err_d;
    logic          mismatch;
    logic          last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_valid_d = err_valid_q;
        first_err_d = first_err_q;
        mismatch    = sa ^ sb;
        last        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = APPLY;
                    cnt_d       = '0;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = '0;
                    err_valid_d = 1'b0;
                    first_err_d = '0;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (!err_valid_q) begin
                        first_err_d = vec_q;
                        err_valid_d = 1'b1;
                    end
                end
`ifdef F5_STOP_ON_MISMATCH_EN
                last = (vec_q == VEC_LAST) || mismatch;
`else
                last = (vec_q == VEC_LAST);
`endif
                // pass uses the updated count so it is valid together with done
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vec_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_valid_q <= err_valid_d;
            first_err_q <= first_err_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_valid = err_valid_q;
    assign first_err = first_err_q;

endmodule
